// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (i_*) and data access
//   (d_*). One access is in flight at a time. The port outputs and the
//   completion outputs are registered. A watchdog aborts an access that gets
//   no m_ack within TIMEOUT busy cycles, and reports it through *_err.
// Ports
//   clk, rst_n                  clock, async active-low reset
//   i_req/i_addr                fetch request (held until i_done)
//   i_done/i_err/i_rdata        fetch completion pulse, timeout flag, data
//   d_req/d_wr/d_addr/d_wdata   data request (held until d_done)
//   d_done/d_err/d_rdata        data completion pulse, timeout flag, load data
//   stall_if/stall_mem          pipeline stalls (combinational)
//   m_req/m_wr/m_addr/m_wdata   memory port request (registered)
//   m_ack/m_rdata               memory port acknowledge and read data
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic        i_err,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        m_req,
  output logic        m_wr,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_e;

  state_e      state_q, state_d;
  logic        last_d_q, last_d_d;
  logic [15:0] cnt_q, cnt_d;
  logic        m_req_q, m_req_d, m_wr_q, m_wr_d;
  logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic        i_done_q, i_done_d, i_err_q, i_err_d;
  logic        d_done_q, d_done_d, d_err_q, d_err_d;
  logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

  // A requester in its done cycle still holds req; masking it keeps the
  // finished request from being granted a second time.
  logic i_act, d_act;
  assign i_act = i_req & ~i_done_q;
  assign d_act = d_req & ~d_done_q;

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    cnt_d     = cnt_q;
    m_req_d   = m_req_q;
    m_wr_d    = m_wr_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_done_d  = 1'b0;
    i_err_d   = 1'b0;
    d_done_d  = 1'b0;
    d_err_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        // Data has priority, except right after a data grant when fetch
        // also waits: this alternates under continuous contention.
        if (d_act && (!i_act || !last_d_q)) begin
          state_d   = DBUSY;
          m_req_d   = 1'b1;
          m_wr_d    = d_wr;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          cnt_d     = '0;
          last_d_d  = 1'b1;
        end else if (i_act) begin
          state_d   = IBUSY;
          m_req_d   = 1'b1;
          m_wr_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
          cnt_d     = '0;
          last_d_d  = 1'b0;
        end
      end
      IBUSY, DBUSY: begin
        if (m_ack) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          if (state_q == IBUSY) begin
            i_done_d  = 1'b1;
            i_rdata_d = m_rdata;
          end else begin
            d_done_d  = 1'b1;
            d_rdata_d = m_wr_q ? '0 : m_rdata;
          end
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          // Ack is checked first, so an ack on the last allowed cycle wins.
          state_d = IDLE;
          m_req_d = 1'b0;
          if (state_q == IBUSY) begin
            i_done_d  = 1'b1;
            i_err_d   = 1'b1;
            i_rdata_d = '0;
          end else begin
            d_done_d  = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      cnt_q     <= '0;
      m_req_q   <= 1'b0;
      m_wr_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_done_q  <= 1'b0;
      i_err_q   <= 1'b0;
      d_done_q  <= 1'b0;
      d_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      cnt_q     <= cnt_d;
      m_req_q   <= m_req_d;
      m_wr_q    <= m_wr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_done_q  <= i_done_d;
      i_err_q   <= i_err_d;
      d_done_q  <= d_done_d;
      d_err_q   <= d_err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign m_req     = m_req_q;
  assign m_wr      = m_wr_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign i_done    = i_done_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_done    = d_done_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign stall_if  = i_req & ~i_done_q;
  assign stall_mem = d_req & ~d_done_q;

endmodule
